// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main controller for a multi-cycle MIPS datapath built around one shared ALU
// and one unified instruction/data memory. Outputs are decoded from the
// current state, plus the opcode where a state serves several instructions.
// Memory states stall on mem_ready. Retired instructions are counted.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   opcode       IR[31:26]
//   funct        IR[5:0]
//   mem_ready    memory completes its access this cycle
//   PCWrite      unconditional PC load
//   PCWriteCond  conditional PC load on branch
//   BranchNE     1: take branch when ALU zero==0; 0: when zero==1
//   IorD         memory address select: 0 PC, 1 ALUOut
//   MemRead      memory read strobe
//   MemWrite     memory write strobe
//   IRWrite      instruction register load
//   MemtoReg     write-back data: 0 ALUOut, 1 MDR
//   PCSource     00 ALU result, 01 ALUOut, 10 jump target, 11 rs (JR)
//   ALUSrcA      0 PC, 1 register A
//   ALUSrcB      00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
//   ALUOp        operation class for the ALU control decoder
//   RegWrite     register-file write
//   RegDst       00 rt, 01 rd, 10 $ra
//   WriteRA      write-data select PC (JAL link)
//   illegal_op   one-cycle pulse on an undecoded opcode
//   instr_count  retired instructions, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int CNT_WIDTH   = 32,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 BranchNE,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic [1:0]           PCSource,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [3:0]           ALUOp,
  output logic                 RegWrite,
  output logic [1:0]           RegDst,
  output logic                 WriteRA,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, R_EXEC, R_WB, I_EXEC, I_WB, MEM_ADDR,
    MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JUMP, JAL, JR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [3:0] AOP_ADD  = 4'b0001;
  localparam logic [3:0] AOP_ORI  = 4'b0010;
  localparam logic [3:0] AOP_ANDI = 4'b0011;
  localparam logic [3:0] AOP_LUI  = 4'b0100;
  localparam logic [3:0] AOP_SW   = 4'b0101;
  localparam logic [3:0] AOP_LW   = 4'b0110;
  localparam logic [3:0] AOP_BEQ  = 4'b0111;
  localparam logic [3:0] AOP_BNE  = 4'b1000;
  localparam logic [3:0] AOP_R    = 4'b1111;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state, next_state;
  logic   retire;
  logic   ready;

  // With waiting disabled every memory access completes in a single cycle.
  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  // Outputs decode from the registered state, so reset clears them (and drops
  // an in-flight MemWrite) asynchronously without any extra logic.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_ONE;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    next_state  = state;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNE    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 4'b0000;
    RegWrite    = 1'b0;
    RegDst      = 2'b00;
    WriteRA     = 1'b0;
    illegal_op  = 1'b0;

    case (state)
      IDLE: next_state = FETCH;

      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = AOP_ADD;
        if (ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = DECODE;
        end
      end

      DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        ALUSrcB = 2'b11;
        ALUOp   = AOP_ADD;
        case (opcode)
          OP_RTYPE:                          next_state = (funct == FN_JR) ? JR : R_EXEC;
          OP_LW, OP_SW:                      next_state = MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  next_state = I_EXEC;
          OP_BEQ, OP_BNE:                    next_state = BRANCH;
          OP_J:                              next_state = JUMP;
          OP_JAL:                            next_state = JAL;
          default: begin
            illegal_op = 1'b1;
            next_state = FETCH;
          end
        endcase
      end

      R_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUOp      = AOP_R;
        next_state = R_WB;
      end

      R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 2'b01;
        retire     = 1'b1;
        next_state = FETCH;
      end

      I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (opcode)
          OP_ANDI: ALUOp = AOP_ANDI;
          OP_ORI:  ALUOp = AOP_ORI;
          OP_LUI:  ALUOp = AOP_LUI;
          default: ALUOp = AOP_ADD;
        endcase
        next_state = I_WB;
      end

      I_WB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end

      MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = (opcode == OP_SW) ? AOP_SW : AOP_LW;
        next_state = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end

      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (ready) next_state = MEM_WB;
      end

      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end

      MEM_WRITE: begin
        // Strobe stays high through stalls; memory commits on the ready cycle.
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (ready) begin
          retire     = 1'b1;
          next_state = FETCH;
        end
      end

      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = (opcode == OP_BNE) ? AOP_BNE : AOP_BEQ;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNE    = (opcode == OP_BNE);
        retire      = 1'b1;
        next_state  = FETCH;
      end

      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        retire     = 1'b1;
        next_state = FETCH;
      end

      JAL: begin
        // PC already holds PC+4 from FETCH, which is the link value.
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        RegWrite   = 1'b1;
        RegDst     = 2'b10;
        WriteRA    = 1'b1;
        retire     = 1'b1;
        next_state = FETCH;
      end

      JR: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b11;
        retire     = 1'b1;
        next_state = FETCH;
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Moore-style main controller that sequences a multi-cycle MIPS datapath over one shared ALU and one unified instruction/data memory. It takes the opcode and funct fields from the instruction register and emits per-state datapath strobes and mux selects. It also emits the 4-bit ALUOp consumed by the existing ALU control decoder. Memory accesses stall on a ready handshake, and the block counts retired instructions.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter
MEM_WAIT_EN, 1, 1: memory states wait for mem_ready; 0: mem_ready treated as constant 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
mem_ready  in  1  memory completes access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  conditional PC load on branch
BranchNE  out  1  1: condition is ALU zero==0; 0: zero==1
IorD  out  1  memory address select: 0 PC, 1 ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  load instruction register
MemtoReg  out  1  write-back data: 0 ALUOut, 1 MDR
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs register (JR)
ALUSrcA  out  1  0 PC, 1 register A
ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign/zero-ext imm, 11 ext imm<<2
ALUOp  out  4  encoded operation class to ALU control
RegWrite  out  1  register-file write
RegDst  out  2  00 rt, 01 rd, 10 $ra (31)
WriteRA  out  1  write-data select PC (JAL link)
illegal_op  out  1  one-cycle pulse on undecoded opcode
instr_count  out  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH

Behaviour:
- Async reset (reset=0): state=IDLE, instr_count=0. All strobes and selects are 0; ALUOp=0000.
- IDLE: all outputs 0. Goes to FETCH unconditionally on the first edge after reset release.
- ALUOp encoding: R-type 1111, ADD 0001 (ADDI/address/PC+4), ORI 0010, ANDI 0011, LUI 0100, SW 0101, LW 0110, BEQ 0111, BNE 1000.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0001, PCSource=00.
  - IRWrite and PCWrite assert only while mem_ready=1; the state then advances to DECODE. Otherwise it holds with IRWrite=PCWrite=0.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=0001 (branch target into ALUOut). Next state by opcode:
  - 000000 with funct 001000 → JR
  - 000000 otherwise → R_EXEC
  - 100011 / 101011 → MEM_ADDR
  - 001000 / 001100 / 001101 / 001111 → I_EXEC
  - 000100 / 000101 → BRANCH
  - 000010 → JUMP
  - 000011 → JAL
  - anything else → FETCH with illegal_op=1 for that cycle; not counted as retired.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=1111 → R_WB.
- R_WB: RegWrite=1, RegDst=01, MemtoReg=0 → FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp per opcode (ADDI 0001, ANDI 0011, ORI 0010, LUI 0100) → I_WB.
- I_WB: RegWrite=1, RegDst=00, MemtoReg=0 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=0110 (LW) or 0101 (SW) → MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: MemRead=1, IorD=1; holds until mem_ready → MEM_WB.
- MEM_WB: RegWrite=1, RegDst=00, MemtoReg=1 → FETCH.
- MEM_WRITE: MemWrite=1, IorD=1; holds until mem_ready → FETCH. MemWrite stays high for every stall cycle; memory commits on the ready cycle.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=0111/1000, PCWriteCond=1, PCSource=01, BranchNE=(opcode==000101) → FETCH.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, WriteRA=1 → FETCH. PC already holds PC+4, so the link value is correct.
- JR: PCWrite=1, PCSource=11 → FETCH.
- Every non-listed output is 0 in each state.
- instr_count increments by 1 on every transition into FETCH from a terminal state: R_WB, I_WB, MEM_WB, MEM_WRITE, BRANCH, JUMP, JAL, JR. No increment on IDLE→FETCH or after an illegal opcode. All-ones wraps to 0.
- Cycle counts with zero-wait memory:
  - R/I-type: 4
  - LW: 5
  - SW: 4
  - Branch/J/JAL/JR: 3
  - Each stall cycle adds 1.
- Reset asserted mid-instruction forces IDLE immediately; an in-flight store is abandoned with MemWrite dropping asynchronously.
- With MEM_WAIT_EN=0, FETCH/MEM_READ/MEM_WRITE last exactly one cycle regardless of mem_ready.

Test Plan:
1. Reset release, mem_ready=1, ADD (op 000000, funct 100000) → IDLE, FETCH(IRWrite=PCWrite=1), DECODE, R_EXEC(ALUOp=1111), R_WB(RegWrite=1, RegDst=01); instr_count=1.
2. LW with mem_ready low 2 cycles in MEM_READ → MEM_READ lasts 3 cycles with MemRead=IorD=1 throughout, then MEM_WB MemtoReg=1; total 7 cycles.
3. BNE (000101) → BRANCH with PCWriteCond=1, BranchNE=1, ALUOp=1000, PCSource=01; BEQ gives BranchNE=0, ALUOp=0111.
4. JAL then JR (funct 001000) → JAL: RegDst=10, WriteRA=1, PCSource=10. JR: PCSource=11, PCWrite=1, RegWrite=0. Count increments by 2.
5. Opcode 111111 → DECODE→FETCH, illegal_op high exactly 1 cycle, instr_count unchanged.
6. SW with reset pulled low during MEM_WRITE stall → MemWrite drops immediately, state IDLE, instr_count=0. Separately, preload count to 2^CNT_WIDTH−1, retire one → 0.
